lcd_frame_streamer: RTL and testbench

Builds a parametrised LINES×COLS character frame from the clock's current time, current date, alarm time, mode and alarm flags, and streams it character-by-character to the LCD write engine over a valid/ready handshake. In edit modes, the field being edited blinks. A frame is re-sent only when displayed content or blink phase changes. Sits between the timekeeping/mode FSM blocks and the LCD bus driver.

---
 rtl/lcd_pkg.sv | 82 ++++++++
 rtl/bin2ascii2.sv | 24 ++
 rtl/lcd_frame_streamer.sv | 238 +++++++++++++++++++++++
 tb/tb_lcd_frame_streamer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - mode codes, field/state enums, ASCII constants and mode helpers
package lcd_pkg;

    localparam logic [5:0] MODE_CUR_TIME          = 6'b000000;
    localparam logic [5:0] MODE_CUR_CTRL_TIME     = 6'b010000;
    localparam logic [5:0] MODE_CUR_CTRL_HOUR     = 6'b010011;
    localparam logic [5:0] MODE_CUR_CTRL_MIN      = 6'b010101;
    localparam logic [5:0] MODE_CUR_CTRL_SEC      = 6'b010111;
    localparam logic [5:0] MODE_CUR_CTRL_MERIDIAN = 6'b011001;
    localparam logic [5:0] MODE_CUR_CTRL_YEAR     = 6'b011011;
    localparam logic [5:0] MODE_CUR_CTRL_MONTH    = 6'b011101;
    localparam logic [5:0] MODE_CUR_CTRL_DAY      = 6'b011111;
    localparam logic [5:0] MODE_ALM_TIME          = 6'b100001;
    localparam logic [5:0] MODE_ALM_CTRL_TIME     = 6'b110001;
    localparam logic [5:0] MODE_ALM_CTRL_HOUR     = 6'b110011;
    localparam logic [5:0] MODE_ALM_CTRL_MIN      = 6'b110101;
    localparam logic [5:0] MODE_ALM_CTRL_SEC      = 6'b110111;

    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_DASH  = 8'h2D;
    localparam logic [7:0] ASCII_A     = 8'h41;
    localparam logic [7:0] ASCII_P     = 8'h50;
    localparam logic [7:0] ASCII_L     = 8'h4C;
    localparam logic [7:0] ASCII_STAR  = 8'h2A;
    localparam logic [7:0] ASCII_BANG  = 8'h21;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;

    typedef enum logic [2:0] {
        FIELD_NONE,
        FIELD_HOUR,
        FIELD_MIN,
        FIELD_SEC,
        FIELD_MERIDIAN,
        FIELD_YEAR,
        FIELD_MONTH,
        FIELD_DAY
    } field_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND
    } state_e;

    typedef struct packed {
        logic [17:0] cur_time;
        logic [15:0] cur_date;
        logic [16:0] alm_time;
        logic [5:0]  mode;
        logic        alm_en;
        logic        alm_doing;
    } snap_t;

    function automatic field_e mode_field(input logic [5:0] mode);
        field_e f;
        case (mode)
            MODE_CUR_CTRL_HOUR, MODE_ALM_CTRL_HOUR: f = FIELD_HOUR;
            MODE_CUR_CTRL_MIN,  MODE_ALM_CTRL_MIN:  f = FIELD_MIN;
            MODE_CUR_CTRL_SEC,  MODE_ALM_CTRL_SEC:  f = FIELD_SEC;
            MODE_CUR_CTRL_MERIDIAN:                 f = FIELD_MERIDIAN;
            MODE_CUR_CTRL_YEAR:                     f = FIELD_YEAR;
            MODE_CUR_CTRL_MONTH:                    f = FIELD_MONTH;
            MODE_CUR_CTRL_DAY:                      f = FIELD_DAY;
            MODE_CUR_TIME, MODE_CUR_CTRL_TIME,
            MODE_ALM_TIME, MODE_ALM_CTRL_TIME:      f = FIELD_NONE;
            default:                                f = FIELD_NONE;
        endcase
        return f;
    endfunction

    // Unlisted codes fall back to the current-time layout even with MODE[5] set.
    function automatic logic is_alarm_layout(input logic [5:0] mode);
        logic a;
        case (mode)
            MODE_ALM_TIME, MODE_ALM_CTRL_TIME, MODE_ALM_CTRL_HOUR,
            MODE_ALM_CTRL_MIN, MODE_ALM_CTRL_SEC: a = 1'b1;
            default:                              a = 1'b0;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/bin2ascii2.sv
// rtl/bin2ascii2.sv - 7-bit binary to two ASCII decimal digits, clamped to "99"
module bin2ascii2
    import lcd_pkg::*;
(
    input  logic [6:0] value,
    output logic [7:0] tens,
    output logic [7:0] ones
);

    logic [6:0] t;
    logic [6:0] o;

    always_comb begin
        t = 7'd9;
        o = 7'd9;
        if (value < 7'd100) begin
            t = value / 7'd10;
            o = value - 7'(t * 7'd10);
        end
        tens = ASCII_ZERO + {1'b0, t};
        ones = ASCII_ZERO + {1'b0, o};
    end

endmodule

// File: rtl/lcd_frame_streamer.sv
// rtl/lcd_frame_streamer.sv - builds the clock display frame and streams it char by char
module lcd_frame_streamer
    import lcd_pkg::*;
#(
    parameter int         COLS       = 16,
    parameter int         LINES      = 2,
    parameter int         BLINK_DIV  = 25_000_000,
    parameter logic [7:0] BLANK_CHAR = 8'h20
) (
    input  logic        CLK,
    input  logic        RESETN,
    input  logic [17:0] CURRENT_TIME,
    input  logic [15:0] CURRENT_DATE,
    input  logic [16:0] ALARM_TIME,
    input  logic [5:0]  MODE,
    input  logic        ALARM_ENABLE,
    input  logic        ALARM_DOING,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [7:0]  OUT_CHAR,
    output logic [((LINES > 1) ? $clog2(LINES) : 1)-1:0] OUT_ROW,
    output logic [((COLS > 1) ? $clog2(COLS) : 1)-1:0]   OUT_COL,
    output logic        OUT_LAST
);

    localparam int ROW_W = (LINES > 1) ? $clog2(LINES) : 1;
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int CNT_W = $clog2(BLINK_DIV);

    state_e           state_q, state_d;
    snap_t            live, snap;
    logic             snap_phase;
    logic             force_q;
    logic             phase_q;
    logic [CNT_W-1:0] blink_cnt;
    logic [5:0]       mode_prev;
    logic             mode_changed, phase_eff, changed;
    logic             take_snap, load_out, advance, finish;

    logic [ROW_W-1:0] lk_row;
    logic [COL_W-1:0] lk_col;
    int               lk_r, lk_c;
    logic             lk_last;
    logic [7:0]       lk_char;
    field_e           lk_fld, blink_fld;

    logic             alm_layout;
    logic [4:0]       src_hour;
    logic [5:0]       src_min, src_sec;
    logic [6:0]       year_full, yy;
    logic [7:0]       hh_t, hh_o, mm_t, mm_o, ss_t, ss_o;
    logic [7:0]       yy_t, yy_o, mo_t, mo_o, dd_t, dd_o;
    logic [7:0]       flag_char;

    assign live = {CURRENT_TIME, CURRENT_DATE, ALARM_TIME, MODE, ALARM_ENABLE, ALARM_DOING};

    // A mode change forces the visible phase in the same cycle it is snapshotted.
    assign mode_changed = (MODE != mode_prev);
    assign phase_eff    = mode_changed | phase_q;
    assign changed      = force_q | (live != snap) | (phase_eff != snap_phase);

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            blink_cnt <= '0;
            phase_q   <= 1'b1;
            mode_prev <= MODE;
        end else begin
            mode_prev <= MODE;
            if (mode_changed) begin
                blink_cnt <= '0;
                phase_q   <= 1'b1;
            end else if (blink_cnt == CNT_W'(BLINK_DIV - 1)) begin
                blink_cnt <= '0;
                phase_q   <= ~phase_q;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        take_snap = 1'b0;
        load_out  = 1'b0;
        advance   = 1'b0;
        finish    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (changed) begin
                    state_d   = ST_LOAD;
                    take_snap = 1'b1;
                end
            end
            ST_LOAD: begin
                state_d  = ST_SEND;
                load_out = 1'b1;
            end
            ST_SEND: begin
                if (OUT_READY) begin
                    if (OUT_LAST) begin
                        state_d = ST_IDLE;
                        finish  = 1'b1;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign OUT_VALID = (state_q == ST_SEND);

    // Lookup runs one position ahead so the registered outputs hold the current char.
    always_comb begin
        lk_row = OUT_ROW;
        lk_col = OUT_COL + 1'b1;
        if (state_q == ST_LOAD) begin
            lk_row = '0;
            lk_col = '0;
        end else if (OUT_COL == COL_W'(COLS - 1)) begin
            lk_row = OUT_ROW + 1'b1;
            lk_col = '0;
        end
    end

    assign lk_r    = int'(lk_row);
    assign lk_c    = int'(lk_col);
    assign lk_last = (lk_row == ROW_W'(LINES - 1)) && (lk_col == COL_W'(COLS - 1));

    assign alm_layout = is_alarm_layout(snap.mode);
    assign src_hour   = alm_layout ? snap.alm_time[16:12] : snap.cur_time[16:12];
    assign src_min    = alm_layout ? snap.alm_time[11:6]  : snap.cur_time[11:6];
    assign src_sec    = alm_layout ? snap.alm_time[5:0]   : snap.cur_time[5:0];
    assign year_full  = snap.cur_date[15:9];
    assign yy         = (year_full >= 7'd100) ? (year_full - 7'd100) : year_full;
    assign blink_fld  = snap_phase ? FIELD_NONE : mode_field(snap.mode);
    assign flag_char  = snap.alm_doing ? ASCII_BANG : (snap.alm_en ? ASCII_STAR : BLANK_CHAR);

    bin2ascii2 u_hh (.value({2'b00, src_hour}),          .tens(hh_t), .ones(hh_o));
    bin2ascii2 u_mm (.value({1'b0, src_min}),            .tens(mm_t), .ones(mm_o));
    bin2ascii2 u_ss (.value({1'b0, src_sec}),            .tens(ss_t), .ones(ss_o));
    bin2ascii2 u_yy (.value(yy),                         .tens(yy_t), .ones(yy_o));
    bin2ascii2 u_mo (.value({3'b000, snap.cur_date[8:5]}), .tens(mo_t), .ones(mo_o));
    bin2ascii2 u_dd (.value({2'b00, snap.cur_date[4:0]}),  .tens(dd_t), .ones(dd_o));

    always_comb begin
        lk_char = BLANK_CHAR;
        lk_fld  = FIELD_NONE;
        if (lk_r == 0) begin
            if (alm_layout) begin
                case (lk_c)
                    0:  lk_char = ASCII_A;
                    1:  lk_char = ASCII_L;
                    3:  begin lk_char = hh_t; lk_fld = FIELD_HOUR; end
                    4:  begin lk_char = hh_o; lk_fld = FIELD_HOUR; end
                    5:  lk_char = ASCII_COLON;
                    6:  begin lk_char = mm_t; lk_fld = FIELD_MIN; end
                    7:  begin lk_char = mm_o; lk_fld = FIELD_MIN; end
                    8:  lk_char = ASCII_COLON;
                    9:  begin lk_char = ss_t; lk_fld = FIELD_SEC; end
                    10: begin lk_char = ss_o; lk_fld = FIELD_SEC; end
                    12: lk_char = flag_char;
                    default: lk_char = BLANK_CHAR;
                endcase
            end else begin
                case (lk_c)
                    0:  begin
                            lk_char = snap.cur_time[17] ? ASCII_P : ASCII_A;
                            lk_fld  = FIELD_MERIDIAN;
                        end
                    2:  begin lk_char = hh_t; lk_fld = FIELD_HOUR; end
                    3:  begin lk_char = hh_o; lk_fld = FIELD_HOUR; end
                    4:  lk_char = ASCII_COLON;
                    5:  begin lk_char = mm_t; lk_fld = FIELD_MIN; end
                    6:  begin lk_char = mm_o; lk_fld = FIELD_MIN; end
                    7:  lk_char = ASCII_COLON;
                    8:  begin lk_char = ss_t; lk_fld = FIELD_SEC; end
                    9:  begin lk_char = ss_o; lk_fld = FIELD_SEC; end
                    12: lk_char = flag_char;
                    default: lk_char = BLANK_CHAR;
                endcase
            end
        end else if (lk_r == 1 && !alm_layout) begin
            case (lk_c)
                0:  lk_char = ASCII_ZERO + 8'd2;
                1:  lk_char = ASCII_ZERO;
                2:  begin lk_char = yy_t; lk_fld = FIELD_YEAR; end
                3:  begin lk_char = yy_o; lk_fld = FIELD_YEAR; end
                4:  lk_char = ASCII_DASH;
                5:  begin lk_char = mo_t; lk_fld = FIELD_MONTH; end
                6:  begin lk_char = mo_o; lk_fld = FIELD_MONTH; end
                7:  lk_char = ASCII_DASH;
                8:  begin lk_char = dd_t; lk_fld = FIELD_DAY; end
                9:  begin lk_char = dd_o; lk_fld = FIELD_DAY; end
                default: lk_char = BLANK_CHAR;
            endcase
        end
        if (lk_fld != FIELD_NONE && lk_fld == blink_fld) begin
            lk_char = BLANK_CHAR;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            snap       <= '0;
            snap_phase <= 1'b1;
            force_q    <= 1'b1;
            OUT_CHAR   <= BLANK_CHAR;
            OUT_ROW    <= '0;
            OUT_COL    <= '0;
            OUT_LAST   <= 1'b0;
        end else begin
            if (take_snap) begin
                snap       <= live;
                snap_phase <= phase_eff;
                force_q    <= 1'b0;
            end
            if (load_out || advance) begin
                OUT_CHAR <= lk_char;
                OUT_ROW  <= lk_row;
                OUT_COL  <= lk_col;
                OUT_LAST <= lk_last;
            end else if (finish) begin
                OUT_LAST <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lcd_frame_streamer.sv
// tb/tb_lcd_frame_streamer.sv - directed self-checking bench for lcd_frame_streamer
module tb_lcd_frame_streamer;

    logic        CLK = 1'b0;
    logic        RESETN;
    logic [17:0] CURRENT_TIME;
    logic [15:0] CURRENT_DATE;
    logic [16:0] ALARM_TIME;
    logic [5:0]  MODE;
    logic        ALARM_ENABLE;
    logic        ALARM_DOING;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [7:0]  OUT_CHAR;
    logic [0:0]  OUT_ROW;
    logic [3:0]  OUT_COL;
    logic        OUT_LAST;

    int checks = 0;
    int errors = 0;
    int ord_err, last_err, stab_err;

    localparam logic [17:0] TIME_A = {1'b1, 5'd11, 6'd59, 6'd30};
    localparam logic [17:0] TIME_B = {1'b1, 5'd11, 6'd59, 6'd31};
    localparam logic [15:0] DATE_A = {7'd24, 4'd3, 5'd7};
    localparam logic [14:0] RST_VAL = {1'b0, 8'h20, 1'b0, 4'd0, 1'b0};

    always #5 CLK = ~CLK;

    lcd_frame_streamer #(
        .COLS(16), .LINES(2), .BLINK_DIV(100), .BLANK_CHAR(8'h20)
    ) dut (
        .CLK(CLK), .RESETN(RESETN),
        .CURRENT_TIME(CURRENT_TIME), .CURRENT_DATE(CURRENT_DATE),
        .ALARM_TIME(ALARM_TIME), .MODE(MODE),
        .ALARM_ENABLE(ALARM_ENABLE), .ALARM_DOING(ALARM_DOING),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .OUT_CHAR(OUT_CHAR), .OUT_ROW(OUT_ROW), .OUT_COL(OUT_COL), .OUT_LAST(OUT_LAST)
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset(input string tag);
        RESETN = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check_eq(tag, 128'({OUT_VALID, OUT_CHAR, OUT_ROW, OUT_COL, OUT_LAST}), 128'(RST_VAL));
        RESETN = 1'b1;
    endtask

    // Called 1 time unit after a clock edge; returns at the same point after the final accept.
    task automatic capture(input bit stall, input int poke_at, input logic [17:0] poke_val,
                           output int lat, output int len,
                           output logic [127:0] l0, output logic [127:0] l1);
        logic [7:0] pc;
        logic [0:0] pr;
        logic [3:0] pcol;
        bit         stalled;
        int         guard;
        lat = 0; len = 0; l0 = '0; l1 = '0;
        ord_err = 0; last_err = 0; stab_err = 0;
        stalled = 1'b0; guard = 0;
        pc = '0; pr = '0; pcol = '0;
        while (!OUT_VALID && lat < 300) begin
            @(posedge CLK); #1;
            lat++;
        end
        while (len < 32 && guard < 600) begin
            OUT_READY = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stalled && (!OUT_VALID || OUT_CHAR != pc || OUT_ROW != pr || OUT_COL != pcol))
                stab_err++;
            if (!OUT_VALID && len > 0)
                stab_err++;
            if (OUT_VALID && OUT_READY) begin
                if (int'(OUT_ROW) != len / 16 || int'(OUT_COL) != len % 16) ord_err++;
                if (OUT_LAST != (len == 31)) last_err++;
                if (len < 16) l0[127 - 8*len -: 8] = OUT_CHAR;
                else          l1[127 - 8*(len-16) -: 8] = OUT_CHAR;
                len++;
                if (len == poke_at) CURRENT_TIME = poke_val;
                stalled = 1'b0;
            end else begin
                stalled = OUT_VALID;
                pc = OUT_CHAR; pr = OUT_ROW; pcol = OUT_COL;
            end
            @(posedge CLK); #1;
            guard++;
        end
        OUT_READY = 1'b1;
    endtask

    task automatic run_frame(input string tag, input bit stall, input int poke_at,
                             input logic [17:0] poke_val, input int exp_lat,
                             input logic [127:0] e0, input logic [127:0] e1);
        int lat, len;
        logic [127:0] l0, l1;
        capture(stall, poke_at, poke_val, lat, len, l0, l1);
        if (exp_lat >= 0) check_eq({tag, "_lat"}, 128'(lat), 128'(exp_lat));
        check_eq({tag, "_len"},   128'(len), 128'(32));
        check_eq({tag, "_line0"}, l0, e0);
        check_eq({tag, "_line1"}, l1, e1);
        check_eq({tag, "_order"}, 128'(ord_err), 128'(0));
        check_eq({tag, "_last"},  128'(last_err), 128'(0));
        check_eq({tag, "_stable"}, 128'(stab_err), 128'(0));
    endtask

    initial begin
        int seen;
        RESETN = 1'b0;
        OUT_READY = 1'b1;
        CURRENT_TIME = TIME_A;
        CURRENT_DATE = DATE_A;
        ALARM_TIME = '0;
        MODE = 6'b000000;
        ALARM_ENABLE = 1'b0;
        ALARM_DOING = 1'b0;

        // Basic frame after reset, then silence while inputs hold still
        do_reset("t1_rst");
        run_frame("t1", 1'b0, -1, '0, 2, "P 11:59:30      ", "2024-03-07      ");
        seen = 0;
        repeat (50) begin
            @(posedge CLK); #1;
            if (OUT_VALID) seen++;
        end
        check_eq("t1_static_idle", 128'(seen), 128'(0));

        // Random back-pressure
        do_reset("t2_rst");
        run_frame("t2", 1'b1, -1, '0, 2, "P 11:59:30      ", "2024-03-07      ");

        // Seconds change mid-frame lands in the following frame
        CURRENT_TIME = TIME_A;
        do_reset("t3_rst");
        run_frame("t3a", 1'b0, 10, TIME_B, 2, "P 11:59:30      ", "2024-03-07      ");
        run_frame("t3b", 1'b0, -1, '0, 2, "P 11:59:31      ", "2024-03-07      ");

        // Blink of the minute field, then a mode change restores visibility at once
        CURRENT_TIME = TIME_B;
        MODE = 6'b010101;
        do_reset("t4_rst");
        run_frame("t4a", 1'b0, -1, '0, 2,  "P 11:59:31      ", "2024-03-07      ");
        run_frame("t4b", 1'b0, -1, '0, -1, "P 11:  :31      ", "2024-03-07      ");
        MODE = 6'b010011;
        run_frame("t4c", 1'b0, -1, '0, 2,  "P 11:59:31      ", "2024-03-07      ");
        run_frame("t4d", 1'b0, -1, '0, -1, "P   :59:31      ", "2024-03-07      ");

        // Alarm layout with enable, then ringing
        MODE = 6'b110001;
        ALARM_TIME = {5'd6, 6'd5, 6'd0};
        ALARM_ENABLE = 1'b1;
        do_reset("t5_rst");
        run_frame("t5a", 1'b0, -1, '0, 2, "AL 06:05:00 *   ", "                ");
        ALARM_DOING = 1'b1;
        run_frame("t5b", 1'b0, -1, '0, 2, "AL 06:05:00 !   ", "                ");

        // Unlisted mode, year wrap, reset in the middle of a frame
        MODE = 6'b111111;
        CURRENT_TIME = {1'b0, 5'd9, 6'd5, 6'd7};
        CURRENT_DATE = {7'd105, 4'd12, 5'd31};
        ALARM_ENABLE = 1'b0;
        do_reset("t6_rst");
        seen = 0;
        while (!OUT_VALID && seen < 10) begin
            @(posedge CLK); #1;
            seen++;
        end
        repeat (10) begin
            @(posedge CLK); #1;
        end
        check_eq("t6_mid_col", 128'(OUT_COL), 128'(10));
        RESETN = 1'b0;
        @(posedge CLK); #1;
        check_eq("t6_mid_rst", 128'({OUT_VALID, OUT_CHAR, OUT_ROW, OUT_COL, OUT_LAST}), 128'(RST_VAL));
        RESETN = 1'b1;
        run_frame("t6", 1'b0, -1, '0, 2, "A 09:05:07  !   ", "2005-12-31      ");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end

endmodule
